// File: rtl/keycode_in_fifo.sv
// keycode_in_fifo: Avalon-MM slave that carries 8-bit keycodes from hardware
// (USB/PS2 decoder) to the Nios CPU. The producer pushes into a small FIFO. The
// CPU pops through a four-register window that also exposes status, a sticky
// overflow flag and a maskable, registered level interrupt.
//
// Optional feature: define KEYCODE_IN_DEDUP_EN to drop a non-zero keycode that
// repeats the last accepted one. 0x00 (key release) is always accepted.
//
// Parameters:
//   DEPTH       FIFO entries, power of two, 2..128
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset, sampled on rising clk
//   address     register select: 0 DATA, 1 STATUS, 2 MASK, 3 PEEK
//   chipselect  slave select
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   CPU write data
//   readdata    CPU read data, combinational, zero wait states
//   in_keycode  producer keycode
//   in_valid    producer offers in_keycode this cycle
//   in_ready    ~full, informational only (the producer never stalls)
//   irq         level interrupt to the CPU
module keycode_in_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  in_keycode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrMask   = 2'd2;
  localparam logic [1:0] AddrPeek   = 2'd3;

  // Storage and state
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    mask_q, mask_d;
  logic          irq_q, irq_d;

  // Decoded strobes and FIFO conditions
  logic rd_strobe;
  logic wr_strobe;
  logic empty;
  logic full;
  logic pop;
  logic accept;
  logic push;
  logic drop;
  logic ovf_clear;

  // Only bits [2] and [1:0] of writedata carry meaning.
  logic unused_writedata;
  assign unused_writedata = ^writedata[31:3];

  assign rd_strobe = chipselect & ~read_n;
  assign wr_strobe = chipselect & ~write_n;

  // Both flags come from the registered count, so a same-cycle pop never makes
  // room for a same-cycle push.
  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  assign pop       = rd_strobe & (address == AddrData) & ~empty;
  assign ovf_clear = wr_strobe & (address == AddrStatus) & writedata[2];

`ifdef KEYCODE_IN_DEDUP_EN
  logic [7:0] last_q, last_d;
  logic       repeat_key;

  // A held key re-offered by the decoder is filtered; releases (0x00) pass.
  assign repeat_key = (in_keycode == last_q) & (in_keycode != 8'h00);
  assign accept     = in_valid & ~repeat_key;

  // Updated even when the push is dropped for full, so a key held through a
  // full FIFO is not queued again once space frees up.
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = in_keycode;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= 8'h00;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign accept = in_valid;
`endif

  assign push = accept & ~full;
  assign drop = accept & full;

  // Next-state logic
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mask_d     = mask_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new overflow event beats a simultaneous CPU clear.
    if (ovf_clear) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    if (wr_strobe && (address == AddrMask)) begin
      mask_d = writedata[1:0];
    end

    // Computed from the registered state, so irq trails every state change by
    // one cycle.
    irq_d = (mask_q[0] & ~empty) | (mask_q[1] & overflow_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mask_q     <= 2'b00;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
    end
  end

  // Entry storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_keycode;
    end
  end

  // Register read mux. DATA and PEEK share a format; DATA returns the head as
  // it was before the pop that the same read triggers.
  always_comb begin
    readdata = '0;
    unique case (address)
      AddrData, AddrPeek: begin
        readdata[8] = ~empty;
        if (!empty) begin
          readdata[7:0] = mem_q[rd_ptr_q];
        end
      end
      AddrStatus: begin
        readdata[0]       = empty;
        readdata[1]       = full;
        readdata[2]       = overflow_q;
        readdata[8 +: CW] = count_q;
      end
      AddrMask: begin
        readdata[1:0] = mask_q;
      end
    endcase
  end

  assign in_ready = ~full;
  assign irq      = irq_q;

endmodule

// File: tb/tb_keycode_in_fifo.sv
// tb_keycode_in_fifo: directed bench for keycode_in_fifo (DEPTH = 8). A queue
// model updated on every rising edge predicts in_ready, irq and readdata; a
// compare process checks them mid-cycle on every cycle after reset. Directed
// reads also carry hand-computed literal expectations. Define
// KEYCODE_IN_DEDUP_EN for both bench and design to exercise the repeat filter.
module tb_keycode_in_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_keycode;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  int vectors;
  int miscompares;

  keycode_in_fifo #(
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .read_n    (read_n),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_keycode(in_keycode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit         m_ovf;
  bit [1:0]   m_mask;
  bit         m_irq;
  bit [7:0]   m_last;
  bit         m_started;
  bit         m_rd, m_wr, m_take, m_irq_next;
  int         m_size;

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf     = 1'b0;
      m_mask    = 2'b00;
      m_irq     = 1'b0;
      m_last    = 8'h00;
      m_started = 1'b1;
    end else if (m_started) begin
      m_rd   = chipselect && !read_n;
      m_wr   = chipselect && !write_n;
      m_size = mq.size();
      m_irq_next = (m_mask[0] && m_size != 0) || (m_mask[1] && m_ovf);
      m_take = in_valid;
`ifdef KEYCODE_IN_DEDUP_EN
      if (in_valid && in_keycode != 8'h00 && in_keycode == m_last) m_take = 1'b0;
      if (m_take) m_last = in_keycode;
`endif
      if (m_rd && address == 2'd0 && m_size != 0) void'(mq.pop_front());
      if (m_wr && address == 2'd1 && writedata[2]) m_ovf = 1'b0;
      if (m_take) begin
        if (m_size == DEPTH) m_ovf = 1'b1;
        else mq.push_back(in_keycode);
      end
      if (m_wr && address == 2'd2) m_mask = writedata[1:0];
      m_irq = m_irq_next;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    int sz;
    r  = '0;
    sz = mq.size();
    case (a)
      2'd0, 2'd3: if (sz != 0) r = 32'h100 | 32'(mq[0]);
      2'd1: begin
        r[0] = (sz == 0);
        r[1] = (sz == DEPTH);
        r[2] = m_ovf;
        r    = r | (32'(sz) << 8);
      end
      default: r[1:0] = m_mask;
    endcase
    return r;
  endfunction

  // Compare process: mid-cycle, inputs and registered state are both stable.
  always @(negedge clk) begin
    if (m_started && reset_n) begin
      check("model_in_ready", {31'b0, in_ready}, {31'b0, mq.size() != DEPTH});
      check("model_irq", {31'b0, irq}, {31'b0, m_irq});
      if (chipselect && !read_n) check("model_readdata", readdata, exp_rd(address));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Every task starts 1 time unit after a rising edge and returns at the same
  // point of the next cycle with the bus idle.
  task automatic idle_inputs();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_valid   = 1'b0;
    in_keycode = 8'h00;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic [7:0] k);
    in_valid = 1'b1; in_keycode = k;
    next_cycle();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    check(nm, readdata, exp);
    next_cycle();
  endtask

  task automatic wrt(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    next_cycle();
  endtask

  task automatic push_rd(input logic [7:0] k, input logic [1:0] a, input logic [31:0] exp,
                         input string nm);
    in_valid = 1'b1; in_keycode = k;
    rd(a, exp, nm);
  endtask

  task automatic push_wr(input logic [7:0] k, input logic [1:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_keycode = k;
    wrt(a, d);
  endtask

  // which: 0 checks irq, 1 checks in_ready
  task automatic idle_chk(input string nm, input int which, input logic exp);
    @(negedge clk);
    check(nm, {31'b0, (which == 0) ? irq : in_ready}, {31'b0, exp});
    next_cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] dd_exp[$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    rd(2'd1, 32'h0000_0001, "reset_status");
    idle_chk("reset_irq", 0, 1'b0);
    idle_chk("reset_in_ready", 1, 1'b1);
    rd(2'd2, 32'h0, "reset_mask");

    // Basic flow
    push(8'h1A); push(8'h04); push(8'h16);
    rd(2'd1, 32'h0000_0300, "basic_count3");
    rd(2'd3, 32'h0000_011A, "basic_peek");
    rd(2'd1, 32'h0000_0300, "basic_peek_no_pop");
    rd(2'd0, 32'h0000_011A, "basic_pop0");
    rd(2'd0, 32'h0000_0104, "basic_pop1");
    rd(2'd0, 32'h0000_0116, "basic_pop2");
    rd(2'd0, 32'h0000_0000, "basic_pop_empty");
    rd(2'd1, 32'h0000_0001, "basic_empty_again");
    wrt(2'd0, 32'h0000_00FF);
    wrt(2'd3, 32'h0000_00FF);
    rd(2'd1, 32'h0000_0001, "ignored_writes");

    // Full and overflow
    for (int i = 1; i <= 8; i++) push(8'(i));
    idle_chk("full_in_ready", 1, 1'b0);
    push(8'h09);
    rd(2'd1, 32'h0000_0806, "full_status_ovf");
    for (int i = 1; i <= 8; i++) rd(2'd0, 32'h100 | 32'(i), "full_pop_order");
    rd(2'd1, 32'h0000_0005, "drained_ovf_sticky");
    wrt(2'd1, 32'h0000_0004);
    rd(2'd1, 32'h0000_0001, "ovf_cleared");

    // Push while popping a full FIFO: the push is dropped
    for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
    push_rd(8'h2C, 2'd0, 32'h0000_0131, "full_push_pop_head");
    rd(2'd1, 32'h0000_0704, "full_push_pop_status");
    for (int i = 1; i < 8; i++) rd(2'd0, 32'h100 | 32'(8'h31 + 8'(i)), "full_push_pop_drain");
    wrt(2'd1, 32'h0000_0004);

    // Push while popping an empty FIFO: the push succeeds
    do_reset();
    push_rd(8'h2C, 2'd0, 32'h0000_0000, "empty_push_pop_read");
    rd(2'd1, 32'h0000_0100, "empty_push_pop_count");
    rd(2'd3, 32'h0000_012C, "empty_push_pop_peek");
    rd(2'd0, 32'h0000_012C, "empty_push_pop_pop");

    // Non-empty interrupt
    wrt(2'd2, 32'h0000_0001);
    rd(2'd2, 32'h0000_0001, "mask_readback");
    push(8'h07);
    idle_chk("irq_ne_plus1", 0, 1'b0);
    idle_chk("irq_ne_plus2", 0, 1'b1);
    rd(2'd0, 32'h0000_0107, "irq_ne_pop");
    idle_chk("irq_after_pop_plus1", 0, 1'b1);
    idle_chk("irq_after_pop_plus2", 0, 1'b0);

    // Overflow interrupt, set beats clear
    wrt(2'd2, 32'h0000_0002);
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
    idle_chk("irq_ovf_masked_ne", 0, 1'b0);
    push(8'h49);
    idle_chk("irq_ovf_plus1", 0, 1'b0);
    idle_chk("irq_ovf_plus2", 0, 1'b1);
    push_wr(8'h4A, 2'd1, 32'h0000_0004);
    rd(2'd1, 32'h0000_0806, "ovf_set_wins");
    idle_chk("irq_ovf_held", 0, 1'b1);
    wrt(2'd1, 32'h0000_0004);
    idle_chk("irq_ovf_clear_plus1", 0, 1'b1);
    idle_chk("irq_ovf_clear_plus2", 0, 1'b0);

    // Reset mid-operation discards the queue
    do_reset();
    rd(2'd1, 32'h0000_0001, "midreset_status");
    rd(2'd2, 32'h0000_0000, "midreset_mask");
    idle_chk("midreset_irq", 0, 1'b0);

    // Repeat filter
    push(8'h04); push(8'h04); push(8'h00); push(8'h00); push(8'h04);
`ifdef KEYCODE_IN_DEDUP_EN
    dd_exp = '{32'h104, 32'h100, 32'h100, 32'h104};
    rd(2'd1, 32'h0000_0400, "dedup_count");
`else
    dd_exp = '{32'h104, 32'h104, 32'h100, 32'h100, 32'h104};
    rd(2'd1, 32'h0000_0500, "nodedup_count");
`endif
    foreach (dd_exp[i]) rd(2'd0, dd_exp[i], "dedup_pop");
    rd(2'd1, 32'h0000_0001, "dedup_no_ovf");

    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keycode_in_fifo.md
Name: keycode_in_fifo

Overview:
- Avalon-MM slave that carries keycodes from hardware to the Nios CPU, the reverse path of the keycode output PIO.
- A hardware producer (USB/PS2 decoder logic) pushes 8-bit keycodes into a small FIFO.
- The CPU pops them through a register window, with status, sticky overflow and a maskable level interrupt.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..128; count field width CW = log2(DEPTH)+1

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset, sampled on rising clk
address  in  2  register select
chipselect  in  1  slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  CPU write data
readdata  out  32  CPU read data, combinational, zero wait states
in_keycode  in  8  producer keycode
in_valid  in  1  producer offers in_keycode this cycle
in_ready  out  1  = ~full; informational, producer does not stall
irq  out  1  level interrupt to CPU

Behaviour:
- Reset: synchronous active-low, applied on the rising clk edge with reset_n=0.
  - Reset clears pointers, count=0, overflow=0, mask=0 and the dedup register (if present).
  - After reset: irq=0, in_ready=1.
  - Reset mid-operation discards all queued entries.
- Strobe definitions: rd = chipselect & ~read_n; wr = chipselect & ~write_n.
- Register map (readdata bits not listed read 0):
  - addr0 DATA (read): [7:0] head keycode, [8] valid=~empty. A read while non-empty pops one entry at the end of that cycle. Reading while empty returns 0x000 and has no side effect.
  - addr1 STATUS (read): [0] empty, [1] full, [2] overflow, [8+CW-1:8] count. Writing 1 to writedata[2] clears overflow; other write bits are ignored.
  - addr2 MASK (read/write): [0] nonempty irq enable, [1] overflow irq enable. Write updates [1:0] the next cycle.
  - addr3 PEEK (read): same format as DATA, never pops.
  - Writes to addr0 and addr3 are ignored.
- Push: when in_valid & ~full, the entry is written at the tail; count increments next cycle.
  - in_valid & full drops the keycode and sets overflow next cycle.
  - "full" is the value registered before the edge, so a push is dropped on a full FIFO even when a pop occurs in the same cycle.
- Pop and push in the same cycle, FIFO not full and not empty: count unchanged, head advances, tail advances.
- Pop and push in the same cycle, FIFO empty: the pop has no effect, the push succeeds, and count becomes 1.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count ranges 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- Overflow is sticky:
  - The CPU clear and a new overflow event in the same cycle leave overflow = 1 (set wins).
  - Overflow never alters FIFO contents.
- irq = (mask[0] & ~empty) | (mask[1] & overflow), registered.
  - Updates one cycle after the state change.
  - Deasserts one cycle after the pop that empties the FIFO, or after the overflow clear.
- readdata reflects the registered state in the same cycle as the strobe. The DATA read returns the pre-pop head.
- in_ready = ~full, combinational from the registered count.

Optional Feature:
- Macro: KEYCODE_IN_DEDUP_EN.
- When defined, a last_accepted register (reset 0x00) filters repeats:
  - A push with in_keycode == last_accepted and in_keycode != 0x00 is silently discarded. It does not count as overflow.
  - in_keycode 0x00 (key release) is always accepted.
  - Every accepted push, including a push dropped for full, updates last_accepted. A key held through a full FIFO is therefore not re-queued later.
- When not defined, every in_valid keycode is pushed subject only to full; no last_accepted register exists.

Test Plan:
- Reset: hold reset_n=0 for 2 clk, then read addr1 -> readdata=0x0000_0001 (empty), irq=0, in_ready=1.
- Basic flow:
  - Push 0x1A, 0x04, 0x16 on consecutive cycles; read addr1 -> count=3.
  - Read addr3 -> 0x11A and count stays 3.
  - Three addr0 reads -> 0x11A, 0x104, 0x116; a fourth read -> 0x000.
- Full and overflow (DEPTH=8):
  - Push 9 keycodes 0x01..0x09 -> in_ready=0 after the 8th; addr1 shows full=1, overflow=1, count=8.
  - Pops return 0x01..0x08; 0x09 is lost.
  - Write addr1 = 0x4 -> overflow=0.
- Simultaneous push and pop:
  - Full FIFO, push 0x2C while reading addr0 -> 0x2C dropped, overflow set, count=7.
  - Empty FIFO, same stimulus -> count=1, head=0x2C.
- Interrupt:
  - MASK=0x1, push 0x07 -> irq=1 two cycles after in_valid; pop -> irq=0 one cycle later.
  - MASK=0x2 plus overflow -> irq=1 until overflow is cleared.
- Dedup (KEYCODE_IN_DEDUP_EN defined): push 0x04, 0x04, 0x00, 0x00, 0x04 -> the FIFO holds 0x04, 0x00, 0x00, 0x04; overflow=0.
